// File: rtl/pipeline_1.sv
// rtl/pipeline_1.sv - 3-stage pipelined 16-lane dot-product neuron core (optional macro SIGNED_W_EN: signed weights)
module pipeline_1 #(
    parameter int LANES = 16,
    parameter int DW    = 8,
    parameter int SW    = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LANES*DW-1:0] p,
    input  logic [LANES*DW-1:0] w,
    output logic [SW-1:0]       s
);

`ifdef SIGNED_W_EN
    // One extra bit holds the sign of an unsigned-pixel by signed-weight product.
    localparam int PW = 2*DW + 1;
`else
    localparam int PW = 2*DW;
`endif
    // Four products per partial sum need two growth bits.
    localparam int PSW    = PW + 2;
    localparam int GROUPS = LANES / 4;

    logic [PW-1:0]  prod_d [LANES];
    logic [PW-1:0]  prod_q [LANES];
    logic [PSW-1:0] psum_d [GROUPS];
    logic [PSW-1:0] psum_q [GROUPS];
    logic [SW-1:0]  s_d;
    logic [SW-1:0]  s_q;

    assign s = s_q;

    // Operands are extended to the product width first; the low PW bits of the
    // product are then correct for both the unsigned and the signed-weight case.
    function automatic logic [PW-1:0] mul_lane(input logic [DW-1:0] pv, input logic [DW-1:0] wv);
        logic [PW-1:0] pe;
        logic [PW-1:0] we;
        pe = {{(PW-DW){1'b0}}, pv};
`ifdef SIGNED_W_EN
        we = {{(PW-DW){wv[DW-1]}}, wv};
`else
        we = {{(PW-DW){1'b0}}, wv};
`endif
        return pe * we;
    endfunction

    function automatic logic [PSW-1:0] ext_prod(input logic [PW-1:0] x);
`ifdef SIGNED_W_EN
        return {{(PSW-PW){x[PW-1]}}, x};
`else
        return {{(PSW-PW){1'b0}}, x};
`endif
    endfunction

    function automatic logic [SW-1:0] ext_psum(input logic [PSW-1:0] x);
`ifdef SIGNED_W_EN
        return {{(SW-PSW){x[PSW-1]}}, x};
`else
        return {{(SW-PSW){1'b0}}, x};
`endif
    endfunction

    // Stage 1 inputs: one product per lane.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = mul_lane(p[DW*i +: DW], w[DW*i +: DW]);
        end
    end

    // Stage 2 inputs: partial k adds products 4k..4k+3.
    always_comb begin
        for (int k = 0; k < GROUPS; k++) begin
            psum_d[k] = '0;
            for (int j = 0; j < 4; j++) begin
                psum_d[k] = psum_d[k] + ext_prod(prod_q[4*k + j]);
            end
        end
    end

    // Stage 3 input: total of the partial sums.
    always_comb begin
        s_d = '0;
        for (int k = 0; k < GROUPS; k++) begin
            s_d = s_d + ext_psum(psum_q[k]);
        end
    end

    // Pipeline registers; reset discards everything in flight immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
            end
            for (int k = 0; k < GROUPS; k++) begin
                psum_q[k] <= '0;
            end
            s_q <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= prod_d[i];
            end
            for (int k = 0; k < GROUPS; k++) begin
                psum_q[k] <= psum_d[k];
            end
            s_q <= s_d;
        end
    end

endmodule

// File: tb/tb_pipeline_1.sv
// tb/tb_pipeline_1.sv - directed self-checking bench for pipeline_1
module tb_pipeline_1;

    logic         clk;
    logic         rst_n;
    logic [127:0] p;
    logic [127:0] w;
    logic [19:0]  s;

    int n_checks;
    int n_fail;

    pipeline_1 #(.LANES(16), .DW(8), .SW(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .p     (p),
        .w     (w),
        .s     (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%05h expected 0x%05h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] fill(input logic [7:0] b);
        return {16{b}};
    endfunction

    function automatic logic [127:0] lane(input int idx, input logic [7:0] b);
        logic [127:0] v;
        v = '0;
        v[8*idx +: 8] = b;
        return v;
    endfunction

    // Present a vector pair, let one rising edge consume it, settle 1 time unit.
    task automatic drive(input logic [127:0] pv, input logic [127:0] wv);
        p = pv;
        w = wv;
        @(posedge clk);
        #1;
    endtask

    logic [127:0] pm;
    logic [127:0] wm;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        p        = '0;
        w        = '0;

        // Held in reset with random data.
        for (int c = 0; c < 4; c++) begin
            drive({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
            check("reset_hold", s, 20'h0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive('0, '0);
            check("post_reset_zero", s, 20'h0);
        end

        // Single lane 0: 3*5 = 15, with latency check on the preceding edge.
        drive(lane(0, 8'h03), lane(0, 8'h05));
        drive('0, '0);
        check("single_lane_early", s, 20'h0);
        drive('0, '0);
        check("single_lane", s, 20'h0000F);

        // Lane 15 only: 255*2 = 510 exercises the top of the packing.
        drive(lane(15, 8'hFF), lane(15, 8'h02));
        drive('0, '0);
        drive('0, '0);
        check("lane15", s, 20'h001FE);

        // Mixed lanes: sum i*(i+1), i=0..15 = 1360.
        for (int i = 0; i < 16; i++) begin
            pm[8*i +: 8] = 8'(i);
            wm[8*i +: 8] = 8'(i + 1);
        end
        drive(pm, wm);
        drive('0, '0);
        drive('0, '0);
        check("mixed_lanes", s, 20'h00550);

        // Back-to-back one vector per cycle.
        drive(fill(8'h01), fill(8'h01));
        drive(fill(8'h02), fill(8'h01));
        drive('0, '0);
        check("b2b_0", s, 20'h00010);
        drive('0, '0);
        check("b2b_1", s, 20'h00020);
        drive('0, '0);
        check("b2b_2", s, 20'h00000);

`ifdef SIGNED_W_EN
        drive(fill(8'hFF), fill(8'h80));
        drive('0, '0);
        drive('0, '0);
        check("signed_min", s, 20'h80800);
        drive(lane(0, 8'h02), lane(0, 8'hFF));
        drive('0, '0);
        drive('0, '0);
        check("signed_neg2", s, 20'hFFFFE);
        // Full-scale pixels with weight -1: -16*255 = -4080.
        drive(fill(8'hFF), fill(8'hFF));
        drive(fill(8'hFF), fill(8'hFF));
        drive(fill(8'hFF), fill(8'hFF));
        check("full_scale_signed", s, 20'hFF010);
`else
        drive(fill(8'hFF), fill(8'hFF));
        drive(fill(8'hFF), fill(8'hFF));
        drive(fill(8'hFF), fill(8'hFF));
        check("full_scale", s, 20'hFE010);
`endif

        // Mid-stream asynchronous reset with full-scale data in flight.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_drop", s, 20'h0);
        drive(fill(8'hFF), fill(8'hFF));
        check("async_reset_hold", s, 20'h0);
        rst_n = 1'b1;
        drive(lane(0, 8'h03), lane(0, 8'h05));
        check("release_edge1", s, 20'h0);
        drive('0, '0);
        check("release_edge2", s, 20'h0);
        drive('0, '0);
        check("release_edge3", s, 20'h0000F);
        drive('0, '0);
        check("release_edge4", s, 20'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
